// File: rtl/unlock_arbiter_ctrl.sv
// Arbitrates two key-submit requesters onto a single key comparator guarding the lock
// register; consecutive failures trigger a fixed-length lockout.
module unlock_arbiter_ctrl #(
    parameter int               KEY_W       = 32,
    parameter logic [KEY_W-1:0] KEY         = 32'hA5C3_5A3C,
    parameter int               MAX_FAIL    = 3,
    parameter int               LOCKOUT_CYC = 1024,
    localparam int              FW          = $clog2(MAX_FAIL + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req_valid,
    input  logic [2*KEY_W-1:0] req_key,
    output logic [1:0]         req_ready,
    output logic               resp_valid,
    output logic               resp_ok,
    output logic               resp_id,
    input  logic               relock,
    output logic               locked,
    output logic               lockout,
    output logic [FW-1:0]      fail_cnt
);
    localparam int TW = $clog2(LOCKOUT_CYC + 1);

    typedef enum logic [1:0] {S_LOCKED, S_CHECK, S_UNLOCKED, S_LOCKOUT} state_t;

    state_t        state_q, state_d;
    logic [FW-1:0] fail_q, fail_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          rr_q, rr_d;
    logic          resp_valid_q, resp_valid_d;
    logic          resp_ok_q, resp_ok_d;
    logic          resp_id_q, resp_id_d;
    logic          locked_q, locked_d;
    logic          lockout_q, lockout_d;

    logic [1:0]       grant;
    logic             xfer;
    logic             gid;
    logic [KEY_W-1:0] gkey;
    logic [FW-1:0]    fail_inc;

    // rr_q names the preferred requester; the loser is preferred next time.
    always_comb begin
        grant = 2'b00;
        if (req_valid[rr_q])       grant[rr_q]  = 1'b1;
        else if (req_valid[!rr_q]) grant[!rr_q] = 1'b1;
    end

    assign req_ready = (state_q == S_LOCKED && !reset) ? grant : 2'b00;
    assign xfer      = |req_ready;
    assign gid       = req_ready[1];
    assign gkey      = req_key[gid*KEY_W +: KEY_W];
    assign fail_inc  = fail_q + 1'b1;

    always_comb begin
        state_d = state_q;
        fail_d  = fail_q;
        timer_d = timer_q;
        rr_d    = rr_q;
        case (state_q)
            S_LOCKED: begin
                if (xfer) begin
                    state_d = S_CHECK;
                    rr_d    = ~gid;
                end
            end
            S_CHECK: begin
                if (resp_ok_q) begin
                    fail_d  = '0;
                    state_d = S_UNLOCKED;
                end else begin
                    fail_d = fail_inc;
                    if (fail_inc == FW'(MAX_FAIL)) begin
                        state_d = S_LOCKOUT;
                        timer_d = TW'(LOCKOUT_CYC - 1);
                    end else begin
                        state_d = S_LOCKED;
                    end
                end
            end
            S_UNLOCKED: begin
                if (relock) state_d = S_LOCKED;
            end
            S_LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d = S_LOCKED;
                    fail_d  = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = S_LOCKED;
        endcase
    end

    // Comparison is done at acceptance so the response is a plain register in CHECK.
    always_comb begin
        resp_valid_d = xfer;
        resp_ok_d    = xfer ? (gkey == KEY) : resp_ok_q;
        resp_id_d    = xfer ? gid : resp_id_q;
        locked_d     = (state_d != S_UNLOCKED);
        lockout_d    = (state_d == S_LOCKOUT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_LOCKED;
            fail_q       <= '0;
            timer_q      <= '0;
            rr_q         <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_ok_q    <= 1'b0;
            resp_id_q    <= 1'b0;
            locked_q     <= 1'b1;
            lockout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            fail_q       <= fail_d;
            timer_q      <= timer_d;
            rr_q         <= rr_d;
            resp_valid_q <= resp_valid_d;
            resp_ok_q    <= resp_ok_d;
            resp_id_q    <= resp_id_d;
            locked_q     <= locked_d;
            lockout_q    <= lockout_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_ok    = resp_ok_q;
    assign resp_id    = resp_id_q;
    assign locked     = locked_q;
    assign lockout    = lockout_q;
    assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_unlock_arbiter_ctrl.sv
// Directed vector bench for unlock_arbiter_ctrl: table rows per cycle plus hand-written
// sequences for lockout duration and reset during CHECK.
module tb_unlock_arbiter_ctrl;
    localparam logic [31:0] KEY  = 32'hA5C3_5A3C;
    localparam logic [31:0] BAD0 = 32'h0000_0001;
    localparam logic [31:0] BAD1 = 32'hA5C3_5A3D;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [31:0] k0, k1;
    logic [63:0] req_key;
    logic [1:0]  req_ready;
    logic        resp_valid, resp_ok, resp_id, relock, locked, lockout;
    logic [1:0]  fail_cnt;

    assign req_key = {k1, k0};

    unlock_arbiter_ctrl dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_key(req_key),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_ok(resp_ok),
        .resp_id(resp_id), .relock(relock), .locked(locked), .lockout(lockout),
        .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          seg;
        logic [1:0]  v;
        logic [31:0] k0, k1;
        logic        rl;
        logic [1:0]  rdy;
        logic        rv, ok, id, lk, lo;
        logic [1:0]  fc;
    } row_t;

    row_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    function automatic row_t mk(input int seg, input logic [1:0] v, input logic [31:0] a,
                                input logic [31:0] b, input logic rl, input logic [1:0] rdy,
                                input logic rv, input logic ok, input logic id,
                                input logic lk, input logic lo, input logic [1:0] fc);
        row_t r;
        r.seg = seg; r.v = v; r.k0 = a; r.k1 = b; r.rl = rl; r.rdy = rdy;
        r.rv = rv; r.ok = ok; r.id = id; r.lk = lk; r.lo = lo; r.fc = fc;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; relock = 1'b0; req_valid = 2'b11; k0 = KEY; k1 = KEY;
        #1;
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_locked", int'(locked), 1);
        chk("rst_lockout", int'(lockout), 0);
        chk("rst_rv", int'(resp_valid), 0);
        chk("rst_fc", int'(fail_cnt), 0);
        req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic run_row(input row_t r, input int idx);
        string tag;
        @(posedge clk);
        #1;
        req_valid = r.v; k0 = r.k0; k1 = r.k1; relock = r.rl;
        @(negedge clk);
        tag = $sformatf("s%0d_r%0d", r.seg, idx);
        chk({tag, "_ready"}, int'(req_ready), int'(r.rdy));
        chk({tag, "_rv"}, int'(resp_valid), int'(r.rv));
        if (r.rv) begin
            chk({tag, "_ok"}, int'(resp_ok), int'(r.ok));
            chk({tag, "_id"}, int'(resp_id), int'(r.id));
        end
        chk({tag, "_locked"}, int'(locked), int'(r.lk));
        chk({tag, "_lockout"}, int'(lockout), int'(r.lo));
        chk({tag, "_fc"}, int'(fail_cnt), int'(r.fc));
    endtask

    task automatic run_seg(input int s);
        int n = 0;
        foreach (tbl[i]) if (tbl[i].seg == s) begin
            run_row(tbl[i], n);
            n++;
        end
    endtask

    initial begin
        int cnt, bad_rdy;
        bit done;

        // seg 1: idle after reset, unlock by req0, relock
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(1, 2'b00, BAD0, BAD0, 0, 2'b00, 0, 0, 0, 1, 0, 2'd0));
        tbl.push_back(mk(1, 2'b01, KEY,  BAD0, 0, 2'b01, 0, 0, 0, 1, 0, 2'd0));
        tbl.push_back(mk(1, 2'b00, BAD0, BAD0, 0, 2'b00, 1, 1, 0, 1, 0, 2'd0));
        tbl.push_back(mk(1, 2'b00, BAD0, BAD0, 0, 2'b00, 0, 0, 0, 0, 0, 2'd0));
        tbl.push_back(mk(1, 2'b00, BAD0, BAD0, 0, 2'b00, 0, 0, 0, 0, 0, 2'd0));
        tbl.push_back(mk(1, 2'b00, BAD0, BAD0, 1, 2'b00, 0, 0, 0, 0, 0, 2'd0));
        tbl.push_back(mk(1, 2'b00, BAD0, BAD0, 0, 2'b00, 0, 0, 0, 1, 0, 2'd0));
        // seg 2: contention with wrong keys, round-robin, into lockout
        tbl.push_back(mk(2, 2'b11, BAD0, BAD1, 0, 2'b01, 0, 0, 0, 1, 0, 2'd0));
        tbl.push_back(mk(2, 2'b10, BAD0, BAD1, 0, 2'b00, 1, 0, 0, 1, 0, 2'd0));
        tbl.push_back(mk(2, 2'b10, BAD0, BAD1, 0, 2'b10, 0, 0, 0, 1, 0, 2'd1));
        tbl.push_back(mk(2, 2'b01, BAD1, BAD1, 0, 2'b00, 1, 0, 1, 1, 0, 2'd1));
        tbl.push_back(mk(2, 2'b01, BAD1, BAD1, 0, 2'b01, 0, 0, 0, 1, 0, 2'd2));
        tbl.push_back(mk(2, 2'b00, BAD1, BAD1, 0, 2'b00, 1, 0, 0, 1, 0, 2'd2));
        tbl.push_back(mk(2, 2'b11, BAD0, KEY,  0, 2'b00, 0, 0, 0, 1, 1, 2'd3));
        // seg 3: req1 unlocks after lockout; req0 stalls while unlocked
        tbl.push_back(mk(3, 2'b01, BAD0, BAD0, 0, 2'b00, 1, 1, 1, 1, 0, 2'd0));
        tbl.push_back(mk(3, 2'b01, BAD0, BAD0, 0, 2'b00, 0, 0, 0, 0, 0, 2'd0));
        tbl.push_back(mk(3, 2'b01, BAD0, BAD0, 0, 2'b00, 0, 0, 0, 0, 0, 2'd0));
        tbl.push_back(mk(3, 2'b01, BAD0, BAD0, 1, 2'b00, 0, 0, 0, 0, 0, 2'd0));
        tbl.push_back(mk(3, 2'b01, BAD0, BAD0, 0, 2'b01, 0, 0, 0, 1, 0, 2'd0));
        tbl.push_back(mk(3, 2'b00, BAD0, BAD0, 0, 2'b00, 1, 0, 0, 1, 0, 2'd0));
        tbl.push_back(mk(3, 2'b00, BAD0, BAD0, 0, 2'b00, 0, 0, 0, 1, 0, 2'd1));
        // seg 4: relock ignored in LOCKED/CHECK; two failures then KEY clears count
        tbl.push_back(mk(4, 2'b00, BAD0, BAD0, 1, 2'b00, 0, 0, 0, 1, 0, 2'd0));
        tbl.push_back(mk(4, 2'b01, BAD0, BAD0, 0, 2'b01, 0, 0, 0, 1, 0, 2'd0));
        tbl.push_back(mk(4, 2'b00, BAD0, BAD0, 1, 2'b00, 1, 0, 0, 1, 0, 2'd0));
        tbl.push_back(mk(4, 2'b10, BAD0, BAD1, 0, 2'b10, 0, 0, 0, 1, 0, 2'd1));
        tbl.push_back(mk(4, 2'b00, BAD0, BAD1, 0, 2'b00, 1, 0, 1, 1, 0, 2'd1));
        tbl.push_back(mk(4, 2'b01, KEY,  BAD1, 0, 2'b01, 0, 0, 0, 1, 0, 2'd2));
        tbl.push_back(mk(4, 2'b00, BAD0, BAD0, 0, 2'b00, 1, 1, 0, 1, 0, 2'd2));
        tbl.push_back(mk(4, 2'b00, BAD0, BAD0, 0, 2'b00, 0, 0, 0, 0, 0, 2'd0));

        do_reset();
        run_seg(1);

        do_reset();
        run_seg(2);
        cnt = 1; bad_rdy = 0; done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(posedge clk);
            #1;
            req_valid = 2'b11; k0 = BAD0; k1 = KEY; relock = 1'b0;
            @(negedge clk);
            if (lockout) begin
                cnt++;
                if (req_ready != 2'b00) bad_rdy++;
            end else begin
                done = 1'b1;
            end
        end
        chk("lockout_len", cnt, 1024);
        chk("lockout_ready_zero", bad_rdy, 0);
        chk("post_lockout_fc", int'(fail_cnt), 0);
        chk("post_lockout_ready", int'(req_ready), 2);
        chk("post_lockout_locked", int'(locked), 1);
        run_seg(3);

        // reset during CHECK drops the response and restores rr_ptr
        do_reset();
        @(posedge clk);
        #1 req_valid = 2'b01; k0 = KEY; k1 = BAD1;
        @(negedge clk);
        chk("r5_ready", int'(req_ready), 1);
        @(posedge clk);
        #1 req_valid = 2'b00;
        @(negedge clk);
        chk("r5_check_rv", int'(resp_valid), 1);
        #1 reset = 1'b1;
        #1;
        chk("r5_rst_rv", int'(resp_valid), 0);
        chk("r5_rst_locked", int'(locked), 1);
        @(posedge clk);
        #1 reset = 1'b0; req_valid = 2'b11; k0 = BAD0; k1 = BAD1;
        @(negedge clk);
        chk("r5_rr_ptr", int'(req_ready), 1);
        chk("r5_post_rv", int'(resp_valid), 0);
        chk("r5_post_locked", int'(locked), 1);

        do_reset();
        run_seg(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 500000");
        $fatal(1);
    end
endmodule
